// File: rtl/mul_seq_ctrl.sv
// Control FSM for a repeated-addition multiplier: loads A then B from the shared bus,
// clears P, then steps P<=P+A / B<=B-1 until z, with an iteration watchdog and abort.
module mul_seq_ctrl #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_din_valid,
    input  logic              i_z,
    output logic              o_lda,
    output logic              o_ldb,
    output logic              o_clrp,
    output logic              o_ldp,
    output logic              o_decb,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ITER_W-1:0] o_iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WA,
        S_WB,
        S_CHK,
        S_ADD,
        S_DONE
    } state_t;

    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

    state_t            r_state;
    state_t            w_state_next;
    logic [ITER_W-1:0] r_iter_cnt;
    logic [ITER_W-1:0] w_iter_next;
    logic              r_err;
    logic              w_err_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_iter_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_iter_cnt <= w_iter_next;
            r_err      <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_iter_next  = r_iter_cnt;
        w_err_next   = r_err;
        o_lda        = 1'b0;
        o_ldb        = 1'b0;
        o_clrp       = 1'b0;
        o_ldp        = 1'b0;
        o_decb       = 1'b0;
        o_done       = 1'b0;
        o_busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_WA;
                    w_iter_next  = '0;
                    w_err_next   = 1'b0;
                end
            end
            S_WA: begin
                // abort outranks a simultaneous bus transfer
                if (i_abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    o_lda = i_din_valid;
                    if (i_din_valid) w_state_next = S_WB;
                end
            end
            S_WB: begin
                if (i_abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    o_ldb  = i_din_valid;
                    o_clrp = i_din_valid;
                    if (i_din_valid) w_state_next = S_CHK;
                end
            end
            S_CHK: begin
                if (i_abort) begin
                    w_state_next = S_IDLE;
                end else if (i_z) begin
                    w_state_next = S_DONE;
                end else if (r_iter_cnt == MAX_CNT) begin
                    w_state_next = S_DONE;
                    w_err_next   = 1'b1;
                end else begin
                    w_state_next = S_ADD;
                end
            end
            S_ADD: begin
                if (i_abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    o_ldp        = 1'b1;
                    o_decb       = 1'b1;
                    w_iter_next  = r_iter_cnt + 1'b1;
                    w_state_next = S_CHK;
                end
            end
            S_DONE: begin
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign o_err      = r_err;
    assign o_iter_cnt = r_iter_cnt;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: each operation is expanded into an expected per-cycle trace from
// its operands, bus stalls and abort point; a small datapath model supplies z and the product.
module tb_mul_seq_ctrl;
    localparam int ITER_W   = 8;
    localparam int MAX_ITER = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              dv = 1'b0;
    logic [7:0]        data_in = 8'h00;
    logic              z;
    logic              o_lda, o_ldb, o_clrp, o_ldp, o_decb, o_busy, o_done, o_err;
    logic [ITER_W-1:0] o_iter_cnt;

    mul_seq_ctrl #(.ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .i_din_valid(dv), .i_z(z),
        .o_lda(o_lda), .o_ldb(o_ldb), .o_clrp(o_clrp), .o_ldp(o_ldp), .o_decb(o_decb),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_iter_cnt(o_iter_cnt)
    );

    always #5 clk = ~clk;

    // datapath: A, B and P registers driven by the controller strobes
    logic [7:0]  dp_a = 8'h00;
    logic [7:0]  dp_b = 8'h00;
    logic [15:0] dp_p = 16'h0000;
    always @(posedge clk) begin
        if (o_lda) dp_a <= data_in;
        if (o_ldb) dp_b <= data_in;
        else if (o_decb) dp_b <= dp_b - 8'd1;
        if (o_clrp) dp_p <= 16'h0000;
        else if (o_ldp) dp_p <= dp_p + {8'h00, dp_a};
    end
    assign z = (dp_b == 8'd0);

    // exp = {lda, ldb, clrp, ldp, decb, busy, done, err, iter[7:0]}
    typedef struct {
        logic        st;
        logic        ab;
        logic        v;
        logic [7:0]  d;
        logic [15:0] e;
        logic [15:0] prod;
        bit          pchk;
    } ent_t;

    ent_t        q[$];
    int          tests = 0;
    int          fails = 0;
    logic [7:0]  m_iter = 8'd0;
    logic        m_err = 1'b0;
    int          obs_done;
    int          obs_ldp;
    logic [7:0]  obs_iter;
    logic        obs_err;
    logic [15:0] obs_prod;

    function automatic logic rb();
        return logic'($urandom_range(1, 0));
    endfunction

    function automatic logic [7:0] r8();
        return 8'($urandom_range(255, 0));
    endfunction

    function automatic logic [15:0] pk(input logic lda, ldb, clrp, ldp, decb, busy, done, err,
                                       input logic [7:0] it);
        return {lda, ldb, clrp, ldp, decb, busy, done, err, it};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic st, ab, v, input logic [7:0] d, input logic [15:0] e,
                        input bit pchk, input logic [15:0] prod);
        ent_t x;
        x.st = st; x.ab = ab; x.v = v; x.d = d; x.e = e; x.pchk = pchk; x.prod = prod;
        q.push_back(x);
    endtask

    // Entry index equals the cycle number, with the start-sampling IDLE cycle as 0.
    task automatic build(input logic [7:0] a, input logic [7:0] b, input int wa_st,
                         input int wb_st, input int abort_at);
        int   n;
        logic wd;
        ent_t x;
        q.delete();
        push(1'b1, rb(), rb(), r8(), pk(0,0,0,0,0,0,0,m_err,m_iter), 0, 16'h0);
        for (int s = 0; s < wa_st; s++) push(rb(), 1'b0, 1'b0, r8(), pk(0,0,0,0,0,1,0,0,8'd0), 0, 16'h0);
        push(rb(), 1'b0, 1'b1, a, pk(1,0,0,0,0,1,0,0,8'd0), 0, 16'h0);
        for (int s = 0; s < wb_st; s++) push(rb(), 1'b0, 1'b0, r8(), pk(0,0,0,0,0,1,0,0,8'd0), 0, 16'h0);
        push(rb(), 1'b0, 1'b1, b, pk(0,1,1,0,0,1,0,0,8'd0), 0, 16'h0);
        wd = (int'(b) > MAX_ITER);
        n  = wd ? MAX_ITER : int'(b);
        for (int k = 0; k < n; k++) begin
            push(rb(), 1'b0, rb(), r8(), pk(0,0,0,0,0,1,0,0,8'(k)), 0, 16'h0);
            push(rb(), 1'b0, rb(), r8(), pk(0,0,0,1,1,1,0,0,8'(k)), 0, 16'h0);
        end
        push(rb(), 1'b0, rb(), r8(), pk(0,0,0,0,0,1,0,0,8'(n)), 0, 16'h0);
        push(rb(), rb(), rb(), r8(), pk(0,0,0,0,0,1,1,wd,8'(n)), !wd, 16'(a) * 16'(b));
        push(1'b0, rb(), rb(), r8(), pk(0,0,0,0,0,0,0,wd,8'(n)), 0, 16'h0);
        if (abort_at > 0 && abort_at < q.size() - 2) begin
            x = q[abort_at];
            x.ab = 1'b1;
            x.e[15:11] = 5'b00000;
            q = q[0:abort_at-1];
            q.push_back(x);
            push(1'b0, rb(), rb(), r8(), pk(0,0,0,0,0,0,0,0,x.e[7:0]), 0, 16'h0);
        end
        m_iter = q[q.size()-1].e[7:0];
        m_err  = q[q.size()-1].e[8];
    endtask

    task automatic run(input string tag, input int rst_at);
        logic [15:0] act;
        obs_done = -1;
        obs_ldp  = 0;
        obs_prod = 16'h0;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            start = q[i].st; abort = q[i].ab; dv = q[i].v; data_in = q[i].d;
            #1;
            act = {o_lda, o_ldb, o_clrp, o_ldp, o_decb, o_busy, o_done, o_err, o_iter_cnt};
            check($sformatf("%s_cyc%0d", tag, i), {16'h0, act}, {16'h0, q[i].e});
            if (o_done && obs_done < 0) begin
                obs_done = i;
                obs_prod = dp_p;
            end
            if (o_ldp) obs_ldp++;
            obs_iter = o_iter_cnt;
            obs_err  = o_err;
            if (q[i].pchk) check({tag, "_prod"}, {16'h0, dp_p}, {16'h0, q[i].prod});
            if (i == rst_at) begin
                #2 rst = 1'b1;
                #1;
                act = {o_lda, o_ldb, o_clrp, o_ldp, o_decb, o_busy, o_done, o_err, o_iter_cnt};
                check({tag, "_async_rst"}, {16'h0, act}, 32'h0);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0; start = 1'b0; abort = 1'b0; dv = 1'b0;
                m_iter = 8'd0; m_err = 1'b0;
                #1;
                act = {o_lda, o_ldb, o_clrp, o_ldp, o_decb, o_busy, o_done, o_err, o_iter_cnt};
                check({tag, "_post_rst"}, {16'h0, act}, 32'h0);
                break;
            end
        end
        $display("[TB] op %s: cycles=%0d done_cycle=%0d ldp=%0d iter=%0d err=%0b prod=%0d",
                 tag, q.size(), obs_done, obs_ldp, obs_iter, obs_err, obs_prod);
    endtask

    initial begin
        logic [15:0] act;
        #1 rst = 1'b1;
        #1;
        act = {o_lda, o_ldb, o_clrp, o_ldp, o_decb, o_busy, o_done, o_err, o_iter_cnt};
        check("reset_state", {16'h0, act}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        build(8'd7, 8'd3, 0, 0, 0);
        run("normal", -1);
        check("normal_done_cycle", obs_done, 10);
        check("normal_iter", {24'h0, obs_iter}, 3);
        check("normal_err", {31'h0, obs_err}, 0);
        check("normal_ldp", obs_ldp, 3);
        check("normal_prod", {16'h0, obs_prod}, 21);

        build(8'd5, 8'd0, 0, 0, 0);
        run("zero", -1);
        check("zero_done_cycle", obs_done, 4);
        check("zero_ldp", obs_ldp, 0);
        check("zero_iter", {24'h0, obs_iter}, 0);

        build(8'd7, 8'd3, 5, 2, 0);
        run("stall", -1);
        check("stall_done_cycle", obs_done, 17);

        build(8'd3, 8'd9, 0, 0, 0);
        run("watchdog", -1);
        check("wd_done_cycle", obs_done, 12);
        check("wd_ldp", obs_ldp, 4);
        check("wd_err", {31'h0, obs_err}, 1);
        check("wd_iter", {24'h0, obs_iter}, 4);

        build(8'd2, 8'd5, 0, 0, 8);
        run("abort", -1);
        check("abort_no_done", obs_done, -1);
        check("abort_ldp", obs_ldp, 2);
        check("abort_iter", {24'h0, obs_iter}, 2);

        build(8'd4, 8'd2, 0, 0, 0);
        run("after_abort", -1);
        check("after_abort_done_cycle", obs_done, 8);
        check("after_abort_prod", {16'h0, obs_prod}, 8);

        build(8'd9, 8'd4, 0, 0, 0);
        run("reset_mid_add", 6);

        for (int t = 0; t < 40; t++) begin
            int ab_at;
            ab_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(16, 1)) : 0;
            build(r8(), 8'($urandom_range(MAX_ITER + 3, 0)), int'($urandom_range(3, 0)),
                  int'($urandom_range(3, 0)), ab_at);
            run($sformatf("rand%0d", t), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish, required finish before 1000000");
        $fatal(1, "timeout");
    end
endmodule
